// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus IO window (UART TX FIFO, RX port, cycle counter, stop latch); optional IO_STATS_EN adds a TX pop counter
module mem_io_responder #(
  parameter int ADDR_W = 17,
  parameter int TX_DEPTH = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_stop,
  output logic        tx_overflow
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  logic [7:0] ram [2**ADDR_W];
  logic [7:0] fifo [TX_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nx;
  logic [31:0] cycles;
  logic [31:8] snap;
  logic io, rd, push, pop, accept;
  logic [15:0] off;
  logic [ADDR_W-1:0] ra;
  logic [7:0] push_data, io_rdata;
  logic unused_hi;
`ifdef IO_STATS_EN
  logic [31:0] popped;
  logic [31:8] stats_snap;
`endif
  assign unused_hi = ^mem_a[31:18];
  assign io = mem_a[17:16] == 2'b11;
  assign off = mem_a[15:0];
  assign ra = mem_a[ADDR_W-1:0];
  assign rd = !mem_wr;
  assign tx_valid = count != '0;
  assign tx_data = fifo[rd_ptr];
  // FIFO push/pop decisions; the first stop write enqueues a single 0x00 marker
  always_comb begin
    push = mem_wr && io && ((off == 16'h0000 && mem_dout != 8'h00) || (off == 16'h0004 && !program_stop));
    push_data = off == 16'h0004 ? 8'h00 : mem_dout;
    pop = tx_valid && tx_ready;
    accept = push && (count < CW'(TX_DEPTH) || pop);
    count_nx = count + CW'(accept) - CW'(pop);
  end
  // IO read mux; byte 0 of the counter comes live, bytes 1..3 from the snapshot taken with it
  always_comb begin
    io_rdata = 8'h00;
    case (off)
      16'h0000: io_rdata = rx_valid ? rx_data : 8'h00;
      16'h0004: io_rdata = cycles[7:0];
      16'h0005: io_rdata = snap[15:8];
      16'h0006: io_rdata = snap[23:16];
      16'h0007: io_rdata = snap[31:24];
`ifdef IO_STATS_EN
      16'h0008: io_rdata = popped[7:0];
      16'h0009: io_rdata = stats_snap[15:8];
      16'h000a: io_rdata = stats_snap[23:16];
      16'h000b: io_rdata = stats_snap[31:24];
`endif
      default: io_rdata = 8'h00;
    endcase
  end
  // RAM write port; contents survive reset
  always_ff @(posedge clk_in)
    if (mem_wr && !io) ram[ra] <= mem_dout;
  // FIFO storage
  always_ff @(posedge clk_in)
    if (accept) fifo[wr_ptr] <= push_data;
  // Control state: read data register, counters, FIFO pointers and sticky flags
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_din <= 8'h00;
      io_buffer_full <= 1'b0;
      rx_pop <= 1'b0;
      program_stop <= 1'b0;
      tx_overflow <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      cycles <= '0;
      snap <= '0;
`ifdef IO_STATS_EN
      popped <= '0;
      stats_snap <= '0;
`endif
    end else begin
      cycles <= cycles + 32'd1;
      if (rd) mem_din <= io ? io_rdata : ram[ra];
      rx_pop <= rd && io && off == 16'h0000 && rx_valid;
      if (rd && io && off == 16'h0004) snap <= cycles[31:8];
      if (mem_wr && io && off == 16'h0004) program_stop <= 1'b1;
      if (push && !accept) tx_overflow <= 1'b1;
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_nx;
      io_buffer_full <= count_nx >= CW'(TX_DEPTH - FULL_MARGIN);
`ifdef IO_STATS_EN
      if (pop) popped <= popped + 32'd1;
      if (rd && io && off == 16'h0008) stats_snap <= popped[31:8];
`endif
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed self-checking bench for mem_io_responder
module tb_mem_io_responder;
  logic clk_in = 0, rst_in = 1;
  logic [31:0] mem_a = 0;
  logic [7:0] mem_dout = 0, rx_data = 0;
  logic mem_wr = 0, tx_ready = 0, rx_valid = 0;
  logic [7:0] mem_din, tx_data;
  logic io_buffer_full, tx_valid, rx_pop, program_stop, tx_overflow;
  int n_checks = 0, n_fail = 0;
  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .program_stop(program_stop), .tx_overflow(tx_overflow)
  );
  always #5 clk_in = ~clk_in;
  task automatic cyc;
    @(posedge clk_in);
    #1;
  endtask
  task automatic do_reset;
    rst_in = 1;
    mem_a = 0;
    mem_wr = 0;
    cyc;
    rst_in = 0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a = a;
    mem_dout = d;
    mem_wr = 1;
    cyc;
    mem_wr = 0;
    mem_a = 0;
  endtask
  task automatic rd(input logic [31:0] a);
    mem_a = a;
    mem_wr = 0;
    cyc;
    mem_a = 0;
  endtask
  task automatic drain(output int n, output logic [7:0] first, output logic [7:0] last);
    n = 0;
    first = 8'hxx;
    last = 8'hxx;
    tx_ready = 1;
    for (int i = 0; i < 40; i++) begin
      if (!tx_valid) break;
      if (n == 0) first = tx_data;
      last = tx_data;
      cyc;
      n++;
    end
    tx_ready = 0;
  endtask
  task automatic test_reset;
    do_reset;
    n_checks++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL reset mem_din got %h want 00", mem_din); end
    n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset io_buffer_full got %b want 0", io_buffer_full); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset tx_valid got %b want 0", tx_valid); end
    n_checks++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL reset rx_pop got %b want 0", rx_pop); end
    n_checks++; if (program_stop !== 1'b0) begin n_fail++; $display("FAIL reset program_stop got %b want 0", program_stop); end
    n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL reset tx_overflow got %b want 0", tx_overflow); end
  endtask
  task automatic test_ram;
    wr(32'h10, 8'hA5);
    rd(32'h10);
    n_checks++; if (mem_din !== 8'hA5) begin n_fail++; $display("FAIL ram_rw got %h want a5", mem_din); end
    wr(32'h20020, 8'h5A);
    rd(32'h00020);
    n_checks++; if (mem_din !== 8'h5A) begin n_fail++; $display("FAIL ram_alias got %h want 5a", mem_din); end
    wr(32'h30, 8'h11);
    n_checks++; if (mem_din !== 8'h5A) begin n_fail++; $display("FAIL hold_on_write got %h want 5a", mem_din); end
  endtask
  task automatic test_back_to_back;
    wr(32'h40, 8'h01);
    wr(32'h41, 8'h02);
    mem_a = 32'h40;
    cyc;
    n_checks++; if (mem_din !== 8'h01) begin n_fail++; $display("FAIL b2b_rd0 got %h want 01", mem_din); end
    mem_a = 32'h41;
    cyc;
    n_checks++; if (mem_din !== 8'h02) begin n_fail++; $display("FAIL b2b_rd1 got %h want 02", mem_din); end
    mem_a = 0;
  endtask
  task automatic test_counter;
    logic [7:0] want [4];
    want[0] = 8'h63; want[1] = 8'h00; want[2] = 8'h00; want[3] = 8'h00;
    do_reset;
    repeat (99) cyc;
    for (int i = 0; i < 4; i++) begin
      mem_a = 32'h30004 + i;
      cyc;
      n_checks++; if (mem_din !== want[i]) begin n_fail++; $display("FAIL counter_byte%0d got %h want %h", i, mem_din, want[i]); end
    end
    mem_a = 0;
  endtask
  task automatic test_fifo;
    int n;
    logic [7:0] f, l;
    do_reset;
    for (int i = 0; i < 16; i++) begin
      wr(32'h30000, 8'h41 + 8'(i));
      if (i == 12) begin n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL full_after13 got %b want 0", io_buffer_full); end end
      if (i == 13) begin n_checks++; if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL full_after14 got %b want 1", io_buffer_full); end end
    end
    n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at16 got %b want 0", tx_overflow); end
    tx_ready = 1;
    wr(32'h30000, 8'h99);
    tx_ready = 0;
    n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_push_pop got %b want 0", tx_overflow); end
    drain(n, f, l);
    n_checks++; if (n !== 16) begin n_fail++; $display("FAIL count_push_pop got %0d want 16", n); end
    n_checks++; if (f !== 8'h42) begin n_fail++; $display("FAIL head_push_pop got %h want 42", f); end
    n_checks++; if (l !== 8'h99) begin n_fail++; $display("FAIL tail_push_pop got %h want 99", l); end
    n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL full_after_drain got %b want 0", io_buffer_full); end
    for (int i = 0; i < 16; i++) wr(32'h30000, 8'h41);
    wr(32'h30000, 8'h7E);
    n_checks++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_at17 got %b want 1", tx_overflow); end
    drain(n, f, l);
    n_checks++; if (n !== 16) begin n_fail++; $display("FAIL count_ovf got %0d want 16", n); end
    n_checks++; if (l !== 8'h41) begin n_fail++; $display("FAIL tail_ovf got %h want 41", l); end
  endtask
  task automatic test_program_stop;
    int n;
    logic [7:0] f, l;
    do_reset;
    wr(32'h30000, 8'h00);
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL zero_push got tx_valid %b want 0", tx_valid); end
    wr(32'h30004, 8'h55);
    wr(32'h30004, 8'h66);
    n_checks++; if (program_stop !== 1'b1) begin n_fail++; $display("FAIL program_stop got %b want 1", program_stop); end
    drain(n, f, l);
    n_checks++; if (n !== 1) begin n_fail++; $display("FAIL stop_push_count got %0d want 1", n); end
    n_checks++; if (f !== 8'h00) begin n_fail++; $display("FAIL stop_push_data got %h want 00", f); end
    wr(32'h50, 8'hC3);
    rd(32'h50);
    n_checks++; if (mem_din !== 8'hC3) begin n_fail++; $display("FAIL ram_after_stop got %h want c3", mem_din); end
  endtask
  task automatic test_rx;
    rx_valid = 1;
    rx_data = 8'h37;
    rd(32'h30000);
    n_checks++; if (mem_din !== 8'h37) begin n_fail++; $display("FAIL rx_data got %h want 37", mem_din); end
    n_checks++; if (rx_pop !== 1'b1) begin n_fail++; $display("FAIL rx_pop_high got %b want 1", rx_pop); end
    cyc;
    n_checks++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL rx_pop_pulse got %b want 0", rx_pop); end
    rx_valid = 0;
    rd(32'h30000);
    n_checks++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL rx_empty got %h want 00", mem_din); end
    n_checks++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL rx_nopop got %b want 0", rx_pop); end
  endtask
  task automatic test_other_io;
    rd(32'h10);
    rd(32'h30010);
    n_checks++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL io_unmapped got %h want 00", mem_din); end
`ifndef IO_STATS_EN
    rd(32'h10);
    rd(32'h30008);
    n_checks++; if (mem_din !== 8'h00) begin n_fail++; $display("FAIL io_stats_off got %h want 00", mem_din); end
`endif
  endtask
  task automatic test_reset_mid;
    do_reset;
    for (int i = 0; i < 3; i++) wr(32'h30000, 8'h61 + 8'(i));
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid got %b want 1", tx_valid); end
    tx_ready = 1;
    rst_in = 1;
    cyc;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got %b want 0", tx_valid); end
    rst_in = 0;
    cyc;
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flush got %b want 0", tx_valid); end
    tx_ready = 0;
  endtask
  initial begin
    test_reset;
    test_ram;
    test_back_to_back;
    test_counter;
    test_fifo;
    test_program_stop;
    test_rx;
    test_other_io;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
